// File: rtl/fetch_queue_pkg.sv
// Shared widths, default depth and the entry layout for the fetch queue.
package fetch_queue_pkg;
  localparam int ADDR_WIDTH        = 32;
  localparam int INST_WIDTH        = 32;
  localparam int FETCH_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } FetchEntry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-return and decode-side signals of the fetch queue; the queue is the slave.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
);
  localparam int PTR = $clog2(DEPTH);

  logic                  flush_;
  logic                  inst_e_;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic [INST_WIDTH-1:0] inst;
  logic                  inst_invalid;
  logic                  fetch_stall_;
  logic                  dec_stall_;
  logic                  dec_e_;
  logic [ADDR_WIDTH-1:0] dec_pc;
  logic [INST_WIDTH-1:0] dec_inst;
  logic [PTR:0]          count;

  modport master (
    output flush_, inst_e_, inst_pc, inst, inst_invalid, dec_stall_,
    input  fetch_stall_, dec_e_, dec_pc, dec_inst, count
  );

  modport slave (
    input  flush_, inst_e_, inst_pc, inst, inst_invalid, dec_stall_,
    output fetch_stall_, dec_e_, dec_pc, dec_inst, count
  );
endinterface

// File: rtl/fetch_queue_storage.sv
// fq_storage: DEPTH-entry register file, one write port, asynchronous read port.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter int PTR   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        we,
  input  logic [PTR-1:0] waddr,
  input  FetchEntry_t wdata,
  input  logic [PTR-1:0] raddr,
  output FetchEntry_t rdata
);
  FetchEntry_t mem [DEPTH];

  // Contents are qualified by the queue's count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch return and decode; flushable, with registered
// fetch backpressure. Optional same-cycle bypass when built with FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter int SKID  = 2
) (
  input logic         clk,
  input logic         reset_,
  fetch_queue_if.slave fq
);
  localparam int PTR = $clog2(DEPTH);
  localparam logic [PTR:0] DEPTH_C = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] SKID_C  = (PTR+1)'(SKID);

  logic [PTR-1:0] rd_ptr, wr_ptr;
  logic [PTR:0]   count, count_next;
  logic           fetch_stall_q;
  logic           push_req, push, pop, byp_vis, byp_hit;
  FetchEntry_t    wdata, rdata;

  assign push_req = !fq.inst_e_ && !fq.inst_invalid && fq.flush_;
  assign pop      = (count != '0) && fq.dec_stall_ && fq.flush_;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue: the incoming entry goes straight to decode and is only
  // written if decode does not take it this cycle.
  assign byp_vis = (count == '0) && push_req;
  assign byp_hit = byp_vis && fq.dec_stall_;
`else
  assign byp_vis = 1'b0;
  assign byp_hit = 1'b0;
`endif

  assign push = push_req && !byp_hit && ((count != DEPTH_C) || pop);

  always_comb begin
    count_next = count;
    if (!fq.flush_) count_next = '0;
    else            count_next = count + {{PTR{1'b0}}, push} - {{PTR{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      fetch_stall_q <= 1'b1;
    end else begin
      if (!fq.flush_) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count         <= count_next;
      fetch_stall_q <= !((DEPTH_C - count_next) <= SKID_C);
    end
  end

  assign wdata.pc   = fq.inst_pc;
  assign wdata.inst = fq.inst;

  fq_storage #(.DEPTH(DEPTH), .PTR(PTR)) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Head is zeroed while empty so unreset storage never leaks to decode.
  always_comb begin
    fq.dec_e_   = (count == '0);
    fq.dec_pc   = '0;
    fq.dec_inst = '0;
    if (count != '0) begin
      fq.dec_pc   = rdata.pc;
      fq.dec_inst = rdata.inst;
    end else if (byp_vis) begin
      fq.dec_e_   = 1'b0;
      fq.dec_pc   = fq.inst_pc;
      fq.dec_inst = fq.inst;
    end
  end

  assign fq.fetch_stall_ = fetch_stall_q;
  assign fq.count        = count;

  a_count_bound: assert property (@(posedge clk) disable iff (!reset_) count <= DEPTH_C);
endmodule
